riscv_mc_core: RTL and testbench

// Parametrised multi-cycle RV32I-subset core; successor to riscv_core. Adds width/depth parameters,
// a host load port for instruction memory (no hierarchical pokes), data memory with LW/SW,

---
 rtl/riscv_mc_pkg.sv | 60 ++++++
 rtl/riscv_mc_alu.sv | 34 +++
 rtl/riscv_mc_core.sv | 275 +++++++++++++++++++++++++++
 tb/tb_riscv_mc_core.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core: instruction
// field encodings, FSM state enum, ALU operation enum and the R-type
// funct3/funct7 to ALU-op mapping.
package riscv_mc_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT
  } alu_op_e;

  function automatic alu_op_e rtype_alu_op(input logic [2:0] f3, input logic [6:0] f7);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      F3_ADD_SUB: op = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
      F3_SLT:     op = ALU_SLT;
      F3_XOR:     op = ALU_XOR;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_mc_alu.sv
// Combinational ALU for the multi-cycle core.
//   op_i   : operation select
//   a_i    : first operand
//   b_i    : second operand
//   y_o    : result (mod 2^XLEN; SLT is signed, result 0/1)
//   zero_o : y_o == 0 (used with SUB for branch equality)
module riscv_mc_alu
  import riscv_mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e           op_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [XLEN-1:0]   y_o,
  output logic              zero_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLT: y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: y_o = '0;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/riscv_mc_core.sv
// Multi-cycle RV32I-subset core (ADD SUB AND OR XOR SLT ADDI LW SW BEQ BNE
// ECALL). A host loads instruction memory through the imem_* port while the
// core is idle or halted, pulses start, and waits for halted.
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_we/waddr/wdata : host instruction-memory write (IDLE/HALT only)
//   start             : IDLE/HALT -> FETCH with pc=0
//   busy, halted      : FETCH..WB, HALT
//   illegal           : last halt caused by an unsupported instruction
//   pc                : byte address of the current instruction
//   retire_valid/rd/data : one-cycle pulse per completed instruction
//   dbg_raddr/dbg_rdata  : combinational register-file read
module riscv_mc_core
  import riscv_mc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          start,
  output logic                          busy,
  output logic                          halted,
  output logic                          illegal,
  output logic [XLEN-1:0]               pc,
  output logic                          retire_valid,
  output logic [4:0]                    retire_rd,
  output logic [XLEN-1:0]               retire_data,
  input  logic [$clog2(NREG)-1:0]       dbg_raddr,
  output logic [XLEN-1:0]               dbg_rdata
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam int RAW = $clog2(NREG);
  localparam logic [5:0]      NREG6   = 6'(NREG);
  localparam logic [XLEN-1:0] PC_MASK = XLEN'(IMEM_DEPTH * 4 - 1);

  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];
  logic [XLEN-1:0] rf_q [NREG];

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic            illegal_q, illegal_d;
  logic            rf_we, dmem_we, imem_wr;

  // Instruction fields
  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

  logic is_op, is_lw, is_sw, is_br;
  assign is_op = (opcode == OPC_OP);
  assign is_lw = (opcode == OPC_LOAD);
  assign is_sw = (opcode == OPC_STORE);
  assign is_br = (opcode == OPC_BRANCH);

  // Legality: opcode/funct match plus every used register field < NREG
  logic legal, is_ecall, use_rd, use_rs1, use_rs2;
  always_comb begin
    legal    = 1'b0;
    is_ecall = 1'b0;
    use_rd   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal   = ((f7 == F7_BASE) && (f3 == F3_ADD_SUB || f3 == F3_SLT || f3 == F3_XOR ||
                                       f3 == F3_OR || f3 == F3_AND)) ||
                  ((f7 == F7_SUB) && (f3 == F3_ADD_SUB));
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        legal   = (f3 == F3_ADDI);
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_LOAD: begin
        legal   = (f3 == F3_LW);
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        legal   = (f3 == F3_SW);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        legal   = (f3 == F3_BEQ) || (f3 == F3_BNE);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_SYSTEM: begin
        is_ecall = (ir_q[31:7] == '0);
        legal    = is_ecall;
      end
      default: legal = 1'b0;
    endcase
    if ((use_rd  && ({1'b0, rd}  >= NREG6)) ||
        (use_rs1 && ({1'b0, rs1} >= NREG6)) ||
        (use_rs2 && ({1'b0, rs2} >= NREG6)))
      legal = 1'b0;
  end

  logic [XLEN-1:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == '0) ? '0 : rf_q[rs1[RAW-1:0]];
  assign rs2_val = (rs2 == '0) ? '0 : rf_q[rs2[RAW-1:0]];

  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_b, alu_y;
  logic            alu_zero;

  always_comb begin
    alu_op = ALU_ADD;
    if (is_op)      alu_op = rtype_alu_op(f3, f7);
    else if (is_br) alu_op = ALU_SUB;
    if (is_op || is_br) alu_b = b_q;
    else if (is_sw)     alu_b = imm_s;
    else                alu_b = imm_i;
  end

  riscv_mc_alu #(.XLEN(XLEN)) u_alu (
    .op_i   (alu_op),
    .a_i    (a_q),
    .b_i    (alu_b),
    .y_o    (alu_y),
    .zero_o (alu_zero)
  );

  logic [XLEN-1:0] pc_plus4, pc_br;
  logic            br_taken;
  assign pc_plus4 = (pc_q + XLEN'(4)) & PC_MASK;
  assign pc_br    = (pc_q + imm_b) & PC_MASK;
  assign br_taken = (f3 == F3_BNE) ? !alu_zero : alu_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    illegal_d    = illegal_q;
    rf_we        = 1'b0;
    dmem_we      = 1'b0;
    retire_valid = 1'b0;
    retire_rd    = '0;
    retire_data  = '0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d   = ST_FETCH;
          pc_d      = '0;
          illegal_d = 1'b0;
        end
      end
      ST_FETCH: begin
        ir_d    = imem[pc_q[2 +: IAW]];
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        a_d = rs1_val;
        b_d = rs2_val;
        if (!legal) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else if (is_ecall) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d = alu_y;
        if (is_br) begin
          retire_valid = 1'b1;
          pc_d         = br_taken ? pc_br : pc_plus4;
          state_d      = ST_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (is_sw) begin
          dmem_we      = 1'b1;
          retire_valid = 1'b1;
          pc_d         = pc_plus4;
          state_d      = ST_FETCH;
        end else begin
          res_d   = dmem[res_q[2 +: DAW]];
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        rf_we        = (rd != '0);
        retire_valid = 1'b1;
        retire_rd    = (rd != '0) ? rd : '0;
        retire_data  = (rd != '0) ? res_q : '0;
        pc_d         = pc_plus4;
        state_d      = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register file: x0 is never written so it always reads back as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd[RAW-1:0]] <= res_q;
    end
  end

  // Memories are not reset; write enables derive from reset state, so an
  // in-flight store is dropped when reset asserts.
  assign imem_wr = imem_we && (state_q == ST_IDLE || state_q == ST_HALT);

  always_ff @(posedge clk) begin
    if (imem_wr) imem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (dmem_we) dmem[res_q[2 +: DAW]] <= b_q;
  end

  assign busy      = (state_q inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB});
  assign halted    = (state_q == ST_HALT);
  assign illegal   = illegal_q;
  assign pc        = pc_q;
  assign dbg_rdata = rf_q[dbg_raddr];

endmodule

// File: tb/tb_riscv_mc_core.sv
// Directed self-checking bench for riscv_mc_core.
module tb_riscv_mc_core;

  logic        clk;
  logic        rst_n;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        start;
  logic        busy, halted, illegal;
  logic [31:0] pc;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  riscv_mc_core #(
    .XLEN       (32),
    .NREG       (32),
    .IMEM_DEPTH (64),
    .DMEM_DEPTH (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .start        (start),
    .busy         (busy),
    .halted       (halted),
    .illegal      (illegal),
    .pc           (pc),
    .retire_valid (retire_valid),
    .retire_rd    (retire_rd),
    .retire_data  (retire_data),
    .dbg_raddr    (dbg_raddr),
    .dbg_rdata    (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int taken_at [64];
  logic [4:0]  ret_rd   [$];
  logic [31:0] ret_data [$];
  int          ret_cyc  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] v;
    v = 12'(imm);
    return {v, 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [11:0] v;
    v = 12'(imm);
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [12:0] v;
    v = 13'(imm);
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 7'h13);
  endfunction

  localparam logic [31:0] ECALL = 32'h0000_0073;

  task automatic load_at(input int addr, input logic [31:0] w);
    imem_we    = 1'b1;
    imem_waddr = 6'(addr);
    imem_wdata = w;
    @(negedge clk);
    imem_we    = 1'b0;
  endtask

  task automatic check_reg(input string tag, input int r, input logic [31:0] exp);
    @(negedge clk);
    dbg_raddr = 5'(r);
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  // Pulses start, then samples every falling edge until halted. cyc counts
  // edges after the first FETCH edge. Optional injections at given cycles:
  // reset (returns immediately), host imem write, extra start pulse.
  task automatic run(input int max_cyc, input int rst_at, input int we_at, input int st_at);
    logic        pv;
    logic [31:0] ppc;
    ret_rd.delete();
    ret_data.delete();
    ret_cyc.delete();
    foreach (taken_at[i]) taken_at[i] = 0;
    pv  = 1'b0;
    ppc = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (1) begin
      if (pv && (pc != ((ppc + 32'd4) & 32'hFF))) taken_at[ppc[7:2]]++;
      pv  = retire_valid;
      ppc = pc;
      if (retire_valid) begin
        ret_rd.push_back(retire_rd);
        ret_data.push_back(retire_data);
        ret_cyc.push_back(cyc);
      end
      if (halted || cyc >= max_cyc) break;
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        return;
      end
      imem_we = (cyc == we_at);
      start   = (cyc == st_at);
      @(negedge clk);
      imem_we = 1'b0;
      start   = 1'b0;
      cyc++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_we    = 1'b0;
    imem_waddr = '0;
    imem_wdata = '0;
    start      = 1'b0;
    dbg_raddr  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",    {31'd0, busy},         32'd0);
    check("rst_halted",  {31'd0, halted},       32'd0);
    check("rst_illegal", {31'd0, illegal},      32'd0);
    check("rst_pc",      pc,                    32'd0);
    check("rst_retire",  {31'd0, retire_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_reg("rst_x1", 1, 32'd0);
    check_reg("rst_x31", 31, 32'd0);

    // ALU chain: 5 four-cycle instructions + ECALL
    @(negedge clk);
    load_at(0, addi(2, 0, 5));
    load_at(1, addi(3, 0, 10));
    load_at(2, enc_r(7'h00, 3, 2, 0, 1));   // ADD x1,x2,x3
    load_at(3, enc_r(7'h00, 1, 3, 6, 2));   // OR  x2,x3,x1
    load_at(4, enc_r(7'h00, 2, 1, 7, 3));   // AND x3,x1,x2
    load_at(5, ECALL);
    run(200, -1, -1, -1);
    check("p1_cycles",  cyc,                  32'd22);
    check("p1_retires", ret_rd.size(),        32'd5);
    check("p1_ret0_rd", {27'd0, ret_rd[0]},   32'd2);
    check("p1_ret0_dt", ret_data[0],          32'd5);
    check("p1_illegal", {31'd0, illegal},     32'd0);
    check("p1_busy",    {31'd0, busy},        32'd0);
    check_reg("p1_x1", 1, 32'd15);
    check_reg("p1_x2", 2, 32'd15);
    check_reg("p1_x3", 3, 32'd15);

    // Signed compare and subtraction from zero
    @(negedge clk);
    load_at(0, addi(1, 0, -1));
    load_at(1, enc_r(7'h00, 0, 1, 2, 2));   // SLT x2,x1,x0
    load_at(2, enc_r(7'h20, 1, 0, 0, 3));   // SUB x3,x0,x1
    load_at(3, ECALL);
    run(200, -1, -1, -1);
    check_reg("p2_x1", 1, 32'hFFFF_FFFF);
    check_reg("p2_x2", 2, 32'd1);
    check_reg("p2_x3", 3, 32'd1);

    // Store/load round trip, plus an aliased misaligned address (265 -> word 2)
    @(negedge clk);
    load_at(0, addi(1, 0, 42));
    load_at(1, enc_s(8, 1, 0));              // SW x1,8(x0)
    load_at(2, enc_i(8, 0, 2, 2, 7'h03));    // LW x2,8(x0)
    load_at(3, enc_i(265, 0, 2, 4, 7'h03));  // LW x4,265(x0)
    load_at(4, ECALL);
    run(200, -1, -1, -1);
    check("p3_cycles",  cyc,                  32'd20);
    check("p3_sw_rd",   {27'd0, ret_rd[1]},   32'd0);
    check("p3_lw_cyc",  ret_cyc[2],           32'd12);
    check("p3_lw_rd",   {27'd0, ret_rd[2]},   32'd2);
    check("p3_lw_data", ret_data[2],          32'd42);
    check_reg("p3_x2", 2, 32'd42);
    check_reg("p3_x4", 4, 32'd42);

    // Counted loop: BNE at pc 4 taken while x1 != 0, BEQ x0,x0 jumps back
    @(negedge clk);
    load_at(0, addi(1, 0, 3));
    load_at(1, enc_b(8, 0, 1, 1));           // 4:  BNE x1,x0,+8
    load_at(2, ECALL);                       // 8
    load_at(3, addi(1, 1, -1));              // 12
    load_at(4, enc_b(-12, 0, 0, 0));         // 16: BEQ x0,x0,-12
    run(400, -1, -1, -1);
    check("p4_bne_taken", taken_at[1],        32'd3);
    check("p4_beq_taken", taken_at[4],        32'd3);
    check("p4_pc",        pc,                 32'd8);
    check_reg("p4_x1", 1, 32'd0);

    // Write to x0 is discarded
    @(negedge clk);
    load_at(0, addi(0, 0, 7));
    load_at(1, ECALL);
    run(200, -1, -1, -1);
    check("p5_retires", ret_rd.size(),        32'd1);
    check("p5_ret_rd",  {27'd0, ret_rd[0]},   32'd0);
    check("p5_ret_dt",  ret_data[0],          32'd0);
    check_reg("p5_x0", 0, 32'd0);

    // Unsupported opcode
    @(negedge clk);
    load_at(0, 32'h0000_007F);
    run(200, -1, -1, -1);
    check("p6_illegal", {31'd0, illegal},     32'd1);
    check("p6_halted",  {31'd0, halted},      32'd1);
    check("p6_retires", ret_rd.size(),        32'd0);
    check("p6_cycles",  cyc,                  32'd2);

    // Reset while ADD is in EXEC
    @(negedge clk);
    load_at(0, addi(2, 0, 5));
    load_at(1, addi(3, 0, 10));
    load_at(2, enc_r(7'h00, 3, 2, 0, 1));
    load_at(3, ECALL);
    run(200, 10, -1, -1);
    check("p7_busy",    {31'd0, busy},        32'd0);
    check("p7_halted",  {31'd0, halted},      32'd0);
    check("p7_illegal", {31'd0, illegal},     32'd0);
    check("p7_pc",      pc,                   32'd0);
    check_reg("p7_x1", 1, 32'd0);
    check_reg("p7_x2", 2, 32'd0);
    check_reg("p7_x3", 3, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Host write and start while busy are both ignored
    load_at(0, addi(1, 0, 1));
    load_at(1, ECALL);
    imem_waddr = 6'd1;
    imem_wdata = addi(5, 0, 99);
    run(200, -1, 1, 2);
    check("p8_cycles",  cyc,                  32'd6);
    check("p8_retires", ret_rd.size(),        32'd1);
    check_reg("p8_x5", 5, 32'd0);
    check_reg("p8_x1", 1, 32'd1);

    // Start and host write in the same cycle: fetch sees the new word
    @(negedge clk);
    imem_we    = 1'b1;
    imem_waddr = 6'd0;
    imem_wdata = addi(6, 0, 77);
    run(200, -1, -1, -1);
    check("p9_cycles",  cyc,                  32'd6);
    check_reg("p9_x6", 6, 32'd77);

    // Branch below address 0 wraps to the last instruction word
    @(negedge clk);
    load_at(0, enc_b(-4, 0, 0, 0));          // BEQ x0,x0,-4
    load_at(63, ECALL);
    run(200, -1, -1, -1);
    check("p10_pc",     pc,                   32'h0000_00FC);
    check("p10_cycles", cyc,                  32'd5);
    check("p10_taken",  taken_at[0],          32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
